// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Loads hit in the same cycle; misses and all stores stall until backing memory acks.
module dcache_direct #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned INDEX_BITS = 8,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  stall_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_ack_i,
   output logic [CNT_WIDTH-1:0]  hit_cnt_o,
   output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

   localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
   localparam int unsigned SETS     = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } stateT;

   stateT state, nextState;

   logic [SETS-1:0]       validMem;
   logic [TAG_BITS-1:0]   tagMem  [SETS];
   logic [DATA_WIDTH-1:0] dataMem [SETS];

   logic [INDEX_BITS-1:0] reqIdx, fillIdx, lineIdx;
   logic [TAG_BITS-1:0]   reqTag, fillTag;
   logic                  reqHit;

   logic                  dataWe, fillWe;
   logic [DATA_WIDTH-1:0] lineData;
   logic                  hitInc, missInc, latchReq;

   logic [ADDR_WIDTH-1:0] memAddr;
   logic [DATA_WIDTH-1:0] memWdata;
   logic                  memReq, memWe;
   logic [CNT_WIDTH-1:0]  hitCnt, missCnt;

   // Byte-offset bits never reach the word-organised arrays.
   logic [1:0] unusedAddrBits;
   assign unusedAddrBits = addr_i[1:0];

   assign reqIdx  = addr_i[INDEX_BITS+1:2];
   assign reqTag  = addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
   assign fillIdx = memAddr[INDEX_BITS+1:2];
   assign fillTag = memAddr[ADDR_WIDTH-1:INDEX_BITS+2];
   assign reqHit  = validMem[reqIdx] && (tagMem[reqIdx] == reqTag);

   assign mem_req_o   = memReq;
   assign mem_we_o    = memWe;
   assign mem_addr_o  = memAddr;
   assign mem_wdata_o = memWdata;
   assign hit_cnt_o   = hitCnt;
   assign miss_cnt_o  = missCnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= nextState;
   end

   // Next state, same-cycle load data / stall, and line-update controls.
   always_comb begin
      nextState = state;
      stall_o   = 1'b0;
      rdata_o   = '0;
      dataWe    = 1'b0;
      fillWe    = 1'b0;
      lineIdx   = reqIdx;
      lineData  = wdata_i;
      hitInc    = 1'b0;
      missInc   = 1'b0;
      latchReq  = 1'b0;
      case (state)
         IDLE: begin
            if (req_i) begin
               if (!we_i) begin
                  if (reqHit) begin
                     rdata_o = dataMem[reqIdx];
                     hitInc  = 1'b1;
                  end else begin
                     stall_o   = 1'b1;
                     missInc   = 1'b1;
                     latchReq  = 1'b1;
                     nextState = FILL;
                  end
               end else begin
                  stall_o   = 1'b1;
                  latchReq  = 1'b1;
                  dataWe    = reqHit;
                  nextState = WRITE;
               end
            end
         end
         FILL: begin
            stall_o = !mem_ack_i;
            if (mem_ack_i) begin
               rdata_o   = mem_rdata_i;
               dataWe    = 1'b1;
               fillWe    = 1'b1;
               lineIdx   = fillIdx;
               lineData  = mem_rdata_i;
               nextState = IDLE;
            end
         end
         WRITE: begin
            stall_o = !mem_ack_i;
            if (mem_ack_i) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Memory-side request registers, held stable for the whole transaction.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         memReq   <= 1'b0;
         memWe    <= 1'b0;
         memAddr  <= '0;
         memWdata <= '0;
      end else begin
         memReq <= (nextState != IDLE);
         memWe  <= (nextState == WRITE);
         if (latchReq) begin
            memAddr <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            if (we_i) memWdata <= wdata_i;
         end
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hitCnt  <= '0;
         missCnt <= '0;
      end else begin
         if (hitInc && (hitCnt != '1))   hitCnt  <= hitCnt + CNT_WIDTH'(1);
         if (missInc && (missCnt != '1)) missCnt <= missCnt + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)      validMem <= '0;
      else if (fillWe) validMem[lineIdx] <= 1'b1;
   end

   // Tag and data storage carry no reset; valid bits gate every use.
   always_ff @(posedge clk_i) begin
      if (dataWe) dataMem[lineIdx] <= lineData;
      if (fillWe) tagMem[lineIdx]  <= fillTag;
   end

endmodule

// File: tb/tb_dcache_direct.sv
// Directed bench for dcache_direct: the bench plays backing memory and acks
// on chosen cycles; every expected value below is hand-computed.
module tb_dcache_direct;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   int testsRun    = 0;
   int testsFailed = 0;

   int          stallCnt;
   logic [31:0] seenRdata;
   logic        idleMemReq;
   logic        busyReq, busyWe;
   logic [31:0] busyAddr, busyWdata;

   dcache_direct dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .rdata_o     (rdata_o),
      .stall_o     (stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i),
      .hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o  (miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one access starting just after a rising edge; ack on cycle ackCycle
   // (cycle 0 is the IDLE request cycle). Returns just after the consume edge.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input int ackCycle, input logic [31:0] ackData);
      int  cyc;
      bit  done;
      cyc = 0;
      done = 1'b0;
      stallCnt = 0;
      seenRdata = '0;
      busyReq = 1'b0; busyWe = 1'b0; busyAddr = '0; busyWdata = '0;
      req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
      while (!done && cyc < 40) begin
         if (cyc == ackCycle && cyc > 0) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = ackData;
         end
         @(negedge clk_i);
         if (cyc == 0) idleMemReq = mem_req_o;
         if (cyc == 1) begin
            busyReq = mem_req_o; busyWe = mem_we_o;
            busyAddr = mem_addr_o; busyWdata = mem_wdata_o;
         end
         if (!stall_o) begin
            done = 1'b1;
            seenRdata = rdata_o;
         end else begin
            stallCnt++;
         end
         @(posedge clk_i); #1;
         mem_ack_i = 1'b0;
         cyc++;
      end
      req_i = 1'b0;
      we_i  = 1'b0;
      if (!done) checkVal("access_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
      mem_rdata_i = '0; mem_ack_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checkVal("rst_mem_req",   32'(mem_req_o), 32'd0);
      checkVal("rst_mem_we",    32'(mem_we_o),  32'd0);
      checkVal("rst_mem_addr",  mem_addr_o,     32'd0);
      checkVal("rst_mem_wdata", mem_wdata_o,    32'd0);
      checkVal("rst_hit_cnt",   hit_cnt_o,      32'd0);
      checkVal("rst_miss_cnt",  miss_cnt_o,     32'd0);
      checkVal("rst_rdata",     rdata_o,        32'd0);
      checkVal("rst_stall",     32'(stall_o),   32'd0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      // Cold miss; ack on the third FILL cycle.
      access(1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
      checkVal("miss_stall_cycles", 32'(stallCnt),  32'd3);
      checkVal("miss_rdata_bypass", seenRdata,      32'hDEADBEEF);
      checkVal("miss_idle_memreq",  32'(idleMemReq), 32'd0);
      checkVal("miss_fill_req",     32'(busyReq),   32'd1);
      checkVal("miss_fill_we",      32'(busyWe),    32'd0);
      checkVal("miss_fill_addr",    busyAddr,       32'h100);
      checkVal("miss_cnt_1",        miss_cnt_o,     32'd1);
      checkVal("miss_req_dropped",  32'(mem_req_o), 32'd0);

      // Hit on the same word.
      access(1'b0, 32'h100, 32'h0, 1, 32'h0);
      checkVal("hit_stall_cycles", 32'(stallCnt),   32'd0);
      checkVal("hit_rdata",        seenRdata,       32'hDEADBEEF);
      checkVal("hit_memreq",       32'(idleMemReq), 32'd0);
      checkVal("hit_cnt_1",        hit_cnt_o,       32'd1);
      checkVal("hit_miss_cnt",     miss_cnt_o,      32'd1);

      // Ack while idle must be ignored.
      mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
      @(negedge clk_i);
      checkVal("idle_ack_stall",  32'(stall_o),   32'd0);
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      checkVal("idle_ack_memreq", 32'(mem_req_o), 32'd0);

      // Conflict: 0x500 shares index 0x40 with 0x100; each evicts the other.
      access(1'b0, 32'h500, 32'h0, 1, 32'h11111111);
      checkVal("conflict_a_stall", 32'(stallCnt), 32'd1);
      checkVal("conflict_a_rdata", seenRdata,     32'h11111111);
      access(1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
      checkVal("conflict_b_stall", 32'(stallCnt), 32'd1);
      checkVal("conflict_b_rdata", seenRdata,     32'hDEADBEEF);
      checkVal("conflict_miss_cnt", miss_cnt_o,   32'd3);
      checkVal("conflict_hit_cnt",  hit_cnt_o,    32'd1);

      // Store hit: write-through plus line update.
      access(1'b1, 32'h100, 32'hCAFEF00D, 2, 32'h0);
      checkVal("store_stall_cycles", 32'(stallCnt), 32'd2);
      checkVal("store_mem_req",      32'(busyReq),  32'd1);
      checkVal("store_mem_we",       32'(busyWe),   32'd1);
      checkVal("store_mem_addr",     busyAddr,      32'h100);
      checkVal("store_mem_wdata",    busyWdata,     32'hCAFEF00D);
      checkVal("store_hit_cnt",      hit_cnt_o,     32'd1);
      checkVal("store_miss_cnt",     miss_cnt_o,    32'd3);
      access(1'b0, 32'h100, 32'h0, 1, 32'h0);
      checkVal("after_store_stall", 32'(stallCnt), 32'd0);
      checkVal("after_store_rdata", seenRdata,     32'hCAFEF00D);
      checkVal("after_store_hits",  hit_cnt_o,     32'd2);

      // Store miss must not allocate.
      access(1'b1, 32'h200, 32'h12345678, 1, 32'h0);
      checkVal("store_miss_stall", 32'(stallCnt), 32'd1);
      access(1'b0, 32'h200, 32'h0, 1, 32'hABCD0000);
      checkVal("noalloc_stall",    32'(stallCnt), 32'd1);
      checkVal("noalloc_fill_we",  32'(busyWe),   32'd0);
      checkVal("noalloc_addr",     busyAddr,      32'h200);
      checkVal("noalloc_rdata",    seenRdata,     32'hABCD0000);
      checkVal("noalloc_miss_cnt", miss_cnt_o,    32'd4);

      // Reset in the middle of a FILL.
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h300;
      @(posedge clk_i); #1;
      checkVal("midfill_req_up", 32'(mem_req_o), 32'd1);
      req_i = 1'b0;
      #2 rst_i = 1'b0;
      #1;
      checkVal("midfill_req_async", 32'(mem_req_o), 32'd0);
      checkVal("midfill_hit_cnt",   hit_cnt_o,      32'd0);
      checkVal("midfill_miss_cnt",  miss_cnt_o,     32'd0);
      checkVal("midfill_stall",     32'(stall_o),   32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      access(1'b0, 32'h100, 32'h0, 1, 32'h77777777);
      checkVal("post_rst_stall",    32'(stallCnt), 32'd1);
      checkVal("post_rst_rdata",    seenRdata,     32'h77777777);
      checkVal("post_rst_miss_cnt", miss_cnt_o,    32'd1);
      checkVal("post_rst_hit_cnt",  hit_cnt_o,     32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
